program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 101 ++++++++++
 tb/tb_program_loader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream instruction loader: packs big-endian UART bytes into 32-bit words,
// writes them to instruction memory, and releases the CPU once a halt word or the last address is written.
module program_loader #(
  parameter int MAX_WORDS    = 256,
  parameter int BYTE_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_done,
  input  logic        reload,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        load_done,
  output logic        mips_enable,
  output logic        err_timeout,
  output logic [31:0] word_count
);

  localparam int TW = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BYTE_TIMEOUT - 1);
  localparam logic [31:0]   LAST_ADDR = 32'(MAX_WORDS - 1);

  typedef enum logic {LOAD = 1'b0, DONE = 1'b1} state_t;

  state_t        state, state_next;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   asm_reg;
  logic          final_word;

  // The word being written this cycle ends the program; bytes arriving now are dropped.
  assign final_word = wr_en && ((wr_data == 32'h0) || (wr_addr == LAST_ADDR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (reload)
      state_next = LOAD;
    else if (state == LOAD && final_word)
      state_next = DONE;
  end

  always_comb begin
    load_done   = (state == DONE);
    mips_enable = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt    <= 2'd0;
      tmo_cnt     <= '0;
      asm_reg     <= 32'h0;
      wr_en       <= 1'b0;
      wr_addr     <= 32'h0;
      wr_data     <= 32'h0;
      word_count  <= 32'h0;
      err_timeout <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (reload) begin
        byte_cnt    <= 2'd0;
        tmo_cnt     <= '0;
        asm_reg     <= 32'h0;
        word_count  <= 32'h0;
        err_timeout <= 1'b0;
      end else if (state == LOAD && !final_word) begin
        if (rx_done) begin
          asm_reg <= {asm_reg[23:0], rx_byte};
          tmo_cnt <= '0;
          if (byte_cnt == 2'd3) begin
            byte_cnt   <= 2'd0;
            wr_en      <= 1'b1;
            wr_data    <= {asm_reg[23:0], rx_byte};
            wr_addr    <= word_count;
            word_count <= word_count + 32'd1;
          end else begin
            byte_cnt <= byte_cnt + 2'd1;
          end
        end else if (byte_cnt != 2'd0) begin
          // The idle cycle that would bring the count to BYTE_TIMEOUT aborts the word.
          if (tmo_cnt == TMO_LAST) begin
            byte_cnt    <= 2'd0;
            tmo_cnt     <= '0;
            err_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end else begin
          tmo_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected writes go into a queue that an
// independent monitor drains on every wr_en pulse; status outputs are checked inline.
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_done;
  logic        reload;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        load_done;
  logic        mips_enable;
  logic        err_timeout;
  logic [31:0] word_count;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  program_loader #(.MAX_WORDS(4), .BYTE_TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_done(rx_done), .reload(reload),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .load_done(load_done),
    .mips_enable(mips_enable), .err_timeout(err_timeout), .word_count(word_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drivers
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic send_burst(input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] s;
    s = {w0, w1};
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      rx_byte = s[i*8 +: 8];
      rx_done = 1'b1;
    end
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr", wr_addr, e[63:32]);
        check("write_data", wr_data, e[31:0]);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, {31'b0, wr_en}, 32'd0);
    check({tag, "_wr_addr"}, wr_addr, 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_load_done"}, {31'b0, load_done}, 32'd0);
    check({tag, "_mips_enable"}, {31'b0, mips_enable}, 32'd0);
    check({tag, "_err_timeout"}, {31'b0, err_timeout}, 32'd0);
    check({tag, "_word_count"}, word_count, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rx_byte = 8'h00;
    rx_done = 1'b0;
    reload = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Program of one instruction followed by a halt word
    expect_write(32'd0, 32'h8C010004);
    expect_write(32'd1, 32'h00000000);
    send_word(32'h8C010004);
    send_word(32'h00000000);
    check("halt_wr_en_n1", {31'b0, wr_en}, 32'd1);
    check("halt_not_done_n1", {31'b0, load_done}, 32'd0);
    idle(1);
    check("halt_load_done", {31'b0, load_done}, 32'd1);
    check("halt_mips_enable", {31'b0, mips_enable}, 32'd1);
    check("halt_word_count", word_count, 32'd2);

    // DONE ignores bytes; reload restarts at address 0
    send_byte(8'h55);
    idle(2);
    check("done_ignores_byte", word_count, 32'd2);
    check("done_holds_addr", wr_addr, 32'd1);
    pulse_reload();
    check("reload_load_done", {31'b0, load_done}, 32'd0);
    check("reload_word_count", word_count, 32'd0);
    expect_write(32'd0, 32'h00000000);
    send_word(32'h00000000);
    idle(1);
    check("reload_halt_done", {31'b0, load_done}, 32'd1);

    // Fill all four words, first two back-to-back at line rate
    pulse_reload();
    expect_write(32'd0, 32'h01020304);
    expect_write(32'd1, 32'h05060708);
    expect_write(32'd2, 32'h090A0B0C);
    expect_write(32'd3, 32'h0D0E0F10);
    send_burst(32'h01020304, 32'h05060708);
    check("burst_word_count", word_count, 32'd2);
    send_word(32'h090A0B0C);
    send_word(32'h0D0E0F10);
    idle(1);
    check("full_load_done", {31'b0, load_done}, 32'd1);
    check("full_word_count", word_count, 32'd4);
    send_word(32'h11111111);
    idle(2);
    check("full_extra_bytes", word_count, 32'd4);

    // Partial word abandoned after an idle gap
    pulse_reload();
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("tmo_not_yet", {31'b0, err_timeout}, 32'd0);
    idle(9);
    expect_write(32'd0, 32'h11223344);
    send_word(32'h11223344);
    idle(1);
    check("tmo_err_flag", {31'b0, err_timeout}, 32'd1);
    check("tmo_word_count", word_count, 32'd1);
    check("tmo_still_loading", {31'b0, load_done}, 32'd0);

    // Reset in the middle of a word
    pulse_reload();
    send_byte(8'hDE);
    send_byte(8'hAD);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midword_rst");
    rst = 1'b0;
    expect_write(32'd0, 32'h12345678);
    send_word(32'h12345678);
    idle(1);
    check("rst_resume_count", word_count, 32'd1);

    // Reload coinciding with the write cycle: write still issues, count ends at 0
    expect_write(32'd1, 32'hCAFEBABE);
    send_byte(8'hCA);
    send_byte(8'hFE);
    send_byte(8'hBA);
    @(negedge clk);
    rx_byte = 8'hBE;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_on_write_count", word_count, 32'd0);
    check("reload_on_write_state", {31'b0, load_done}, 32'd0);

    idle(4);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
